othercarleft: RTL and testbench
===============================

# othercarleft

Left-moving traffic lane controller for the Frogger playfield. It holds four cars that share one road row and moves each one left once per video frame. A car that leaves the left edge re-enters past the right edge. The block runs on the system clock, treats `frame_clk` as an asynchronous frame strobe, and updates one car per clock cycle through a small sequencer. Its positions go to the sprite/colour mapper and the collision logic, just as the right-moving lanes do.

## Interface
Parameters:
- `X_START1`, default 144: car 1 reset x.
- `X_START2`, default 0: car 2 reset x.
- `X_START3`, default 432: car 3 reset x.
- `X_START4`, default 288: car 4 reset x.
- `Y_LANE`, default 360: y of all four cars.
- `STEP`, default 2: pixels moved per frame.
- `X_WRAP_LO`, default -32: wrap triggers when x is strictly less than this value.
- `X_WRAP_HI`, default 672: re-entry x after a wrap.

Ports:
- `Clk`, in, 1: system clock; the only clock.
- `Reset`, in, 1: synchronous, active-high.
- `frame_clk`, in, 1: asynchronous frame strobe; only its rising edge is used.
- `halt`, in, 1: freezes traffic (game over or pause).
- `level`, in, 2: speed level; exists only with `OTHERCARLEFT_SPEEDUP_EN`.
- `othercarleft1x`..`othercarleft4x`, out, int (32-bit signed): car x positions.
- `othercarleft1y`..`othercarleft4y`, out, int: car y positions, always `Y_LANE`.
- `othercarleft1dir`..`othercarleft4dir`, out, 1: direction; constant 1 = left.
- `frame_done`, out, 1: one-cycle pulse after all four cars have updated.

## Operation
- Reset: x*n* = `X_START`*n*; y*n* = `Y_LANE`; dir*n* = 1; `frame_done` = 0; FSM in IDLE; sync and edge flops cleared to 0.
- Frame tick: `frame_clk` passes through a two-flop synchronizer and then a previous-value flop. `tick` = sync2 & ~prev. A level held high produces exactly one tick.
- FSM states: IDLE, UPD1, UPD2, UPD3, UPD4.
  - IDLE → UPD1 on `tick` & ~`halt`; otherwise stays in IDLE.
  - UPD*k* updates car *k* and moves to UPD*k+1*.
  - UPD4 updates car 4, pulses `frame_done`, and returns to IDLE.
- Per-car update in UPD*k*, signed compare:
  - If x*k* < `X_WRAP_LO`, then x*k* ← `X_WRAP_HI`.
  - Otherwise x*k* ← x*k* − step.
- Step: `STEP`, or `STEP + level` when the speedup build is enabled.
- Arithmetic: 32-bit signed throughout, with no saturation.
- Boundary: x = `X_WRAP_LO` exactly is not a wrap. It decrements to `X_WRAP_LO` − step, and the next frame wraps.
- `tick` outside IDLE is dropped; nothing queues.
- `halt` rising during UPD1–UPD4: the current sequence completes. Later ticks are ignored while `halt` is high.
- `level` is sampled in each UPD state. A change mid-sequence affects only the cars not yet updated.
- `Reset` has priority in every state. Mid-sequence it restores all reset values at that edge, and no `frame_done` is issued.
- y and dir outputs never change after reset.

## Timing
- Edge n = first `Clk` edge that samples `frame_clk` = 1.
  - Edge n+1: sync2 goes high, so `tick` is high until edge n+2.
  - Edge n+2: IDLE → UPD1.
  - Edges n+3, n+4, n+5, n+6: cars 1, 2, 3, 4 update respectively.
  - Cycle after edge n+6: `frame_done` is high for one cycle; FSM is back in IDLE.
- Latency from `frame_clk` rise to car 1 moving: 3–4 `Clk` cycles, including synchronizer uncertainty.
- Positions are registered outputs. Between frames the cars do not all share the same frame index for 3 cycles; consumers that need a consistent set sample on `frame_done`.

## Configuration
- `OTHERCARLEFT_SPEEDUP_EN` defined:
  - The `level` port exists.
  - Step = `STEP` + `level`, giving 2..5 at default.
- Not defined:
  - The `level` port is absent.
  - Step is fixed at `STEP`.

## Structure
- Shared package `othercar_pkg`:
  - FSM state enum `lane_state_t`, also reused by the right-moving lanes.
  - Default wrap constants: `LANE_X_LEFT_WRAP` = -32, `LANE_X_RIGHT_WRAP` = 672, `LANE_X_RIGHT_EDGE` = 640.
  - `LANE_DIR_LEFT` = 1 and `LANE_DIR_RIGHT` = 0.
- One sub-module, `frame_tick_sync`: two-flop synchronizer plus rising-edge detector. Ports: `Clk`, `Reset`, `frame_clk`, `tick`.

## Test plan
- Reset release → x = 144, 0, 432, 288; all y = 360; all dir = 1; `frame_done` = 0; no movement without a `frame_clk` edge.
- Single `frame_clk` pulse 10 cycles wide → x = 142, −2, 430, 286. Cars update on consecutive edges n+3..n+6, and `frame_done` pulses exactly once, in the cycle after n+6.
- Wrap: preload car 2 via frames to x = −32, then frame → −34, frame → 672, frame → 670.
- `halt` = 1 during 5 frame pulses → positions unchanged, no `frame_done`. Assert `halt` at UPD2 → cars 2–4 still update and `frame_done` still pulses.
- `Reset` asserted in UPD3 → cars 1 and 2 return to 144 and 0, all other reset values restore, and no `frame_done` follows.
- Speedup build with `level` = 3 → one frame moves 144 → 139. Default build → 144 → 142.

Source files
------------

// File: rtl/othercar_pkg.sv
// Definitions shared by the left- and right-moving traffic lanes: sequencer
// states, playfield wrap constants, direction encodings and the per-car move.
package othercar_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UPD1 = 3'd1,
    UPD2 = 3'd2,
    UPD3 = 3'd3,
    UPD4 = 3'd4
  } lane_state_t;

  localparam int LANE_X_LEFT_WRAP  = -32;
  localparam int LANE_X_RIGHT_WRAP = 672;
  localparam int LANE_X_RIGHT_EDGE = 640;

  localparam logic LANE_DIR_LEFT  = 1'b1;
  localparam logic LANE_DIR_RIGHT = 1'b0;

  // A car strictly past the left wrap line re-enters at wrap_hi.
  // A car sitting exactly on the line still moves one more step.
  function automatic logic signed [31:0] lane_step_left(
    input logic signed [31:0] x,
    input logic signed [31:0] step,
    input logic signed [31:0] wrap_lo,
    input logic signed [31:0] wrap_hi
  );
    if (x < wrap_lo) return wrap_hi;
    return x - step;
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame strobe into the Clk domain.
// It produces a one-cycle tick on each rising edge of the strobe.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/othercarleft.sv
// Left-moving lane with four cars. Each frame tick moves one car per Clk
// cycle through UPD1..UPD4, wrapping cars that leave the left edge.
// Define OTHERCARLEFT_SPEEDUP_EN to add the level port (step = STEP + level).
module othercarleft
  import othercar_pkg::*;
#(
  parameter int X_START1  = 144,
  parameter int X_START2  = 0,
  parameter int X_START3  = 432,
  parameter int X_START4  = 288,
  parameter int Y_LANE    = 360,
  parameter int STEP      = 2,
  parameter int X_WRAP_LO = LANE_X_LEFT_WRAP,
  parameter int X_WRAP_HI = LANE_X_RIGHT_WRAP
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic               halt,
`ifdef OTHERCARLEFT_SPEEDUP_EN
  input  logic [1:0]         level,
`endif
  output logic signed [31:0] othercarleft1x,
  output logic signed [31:0] othercarleft2x,
  output logic signed [31:0] othercarleft3x,
  output logic signed [31:0] othercarleft4x,
  output logic signed [31:0] othercarleft1y,
  output logic signed [31:0] othercarleft2y,
  output logic signed [31:0] othercarleft3y,
  output logic signed [31:0] othercarleft4y,
  output logic               othercarleft1dir,
  output logic               othercarleft2dir,
  output logic               othercarleft3dir,
  output logic               othercarleft4dir,
  output logic               frame_done,
  output lane_state_t        dbg_state
);

  logic               tick;
  lane_state_t        state_q, state_d;
  logic signed [31:0] x_q [4];
  logic signed [31:0] x_d [4];
  logic               done_q, done_d;
  logic signed [31:0] step;

  frame_tick_sync u_sync (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

`ifdef OTHERCARLEFT_SPEEDUP_EN
  // level is read live, so a change mid-sequence affects only the remaining cars
  assign step = STEP + $signed({30'd0, level});
`else
  assign step = STEP;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (tick && !halt) state_d = UPD1;
      UPD1: begin
        x_d[0]  = lane_step_left(x_q[0], step, X_WRAP_LO, X_WRAP_HI);
        state_d = UPD2;
      end
      UPD2: begin
        x_d[1]  = lane_step_left(x_q[1], step, X_WRAP_LO, X_WRAP_HI);
        state_d = UPD3;
      end
      UPD3: begin
        x_d[2]  = lane_step_left(x_q[2], step, X_WRAP_LO, X_WRAP_HI);
        state_d = UPD4;
      end
      UPD4: begin
        x_d[3]  = lane_step_left(x_q[3], step, X_WRAP_LO, X_WRAP_HI);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      x_q[0]  <= X_START1;
      x_q[1]  <= X_START2;
      x_q[2]  <= X_START3;
      x_q[3]  <= X_START4;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      done_q  <= done_d;
    end
  end

  assign othercarleft1x   = x_q[0];
  assign othercarleft2x   = x_q[1];
  assign othercarleft3x   = x_q[2];
  assign othercarleft4x   = x_q[3];
  assign othercarleft1y   = Y_LANE;
  assign othercarleft2y   = Y_LANE;
  assign othercarleft3y   = Y_LANE;
  assign othercarleft4y   = Y_LANE;
  assign othercarleft1dir = LANE_DIR_LEFT;
  assign othercarleft2dir = LANE_DIR_LEFT;
  assign othercarleft3dir = LANE_DIR_LEFT;
  assign othercarleft4dir = LANE_DIR_LEFT;
  assign frame_done       = done_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_othercarleft.sv
// Directed bench for othercarleft: reset values, frame timing, wrap boundary,
// halt behaviour and reset in the middle of an update sequence.
module tb_othercarleft;
  import othercar_pkg::*;

`ifdef OTHERCARLEFT_SPEEDUP_EN
  localparam int BSTEP = 5;
`else
  localparam int BSTEP = 2;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic        halt = 1'b0;
`ifdef OTHERCARLEFT_SPEEDUP_EN
  logic [1:0]  level = 2'd3;
`endif
  logic signed [31:0] x1, x2, x3, x4, y1, y2, y3, y4;
  logic        d1, d2, d3, d4;
  logic        frame_done;
  lane_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int m_x [4];
  int obs_x [4];
  int pulses;
  int guard;
  bit found;

  othercarleft dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .frame_clk        (frame_clk),
    .halt             (halt),
`ifdef OTHERCARLEFT_SPEEDUP_EN
    .level            (level),
`endif
    .othercarleft1x   (x1),
    .othercarleft2x   (x2),
    .othercarleft3x   (x3),
    .othercarleft4x   (x4),
    .othercarleft1y   (y1),
    .othercarleft2y   (y2),
    .othercarleft3y   (y3),
    .othercarleft4y   (y4),
    .othercarleft1dir (d1),
    .othercarleft2dir (d2),
    .othercarleft3dir (d3),
    .othercarleft4dir (d4),
    .frame_done       (frame_done),
    .dbg_state        (dbg_state)
  );

  // clock / reset block
  always #5 Clk = ~Clk;

  assign obs_x[0] = x1;
  assign obs_x[1] = x2;
  assign obs_x[2] = x3;
  assign obs_x[3] = x4;

  function automatic int model_move(input int x);
    if (x < -32) return 672;
    return x - BSTEP;
  endfunction

  task automatic model_reset();
    m_x[0] = 144; m_x[1] = 0; m_x[2] = 432; m_x[3] = 288;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_cars(input string tag);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_x%0d", tag, k + 1), obs_x[k], m_x[k]);
  endtask

  // driver: one frame strobe, counting frame_done pulses over the window
  task automatic run_frame(output int cnt);
    cnt = 0;
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (10) begin
      @(negedge Clk);
      if (frame_done) cnt++;
    end
    frame_clk = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      if (frame_done) cnt++;
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    check_cars("reset");
    check("reset_y1", y1, 360);
    check("reset_y4", y4, 360);
    check("reset_dir", int'({d1, d2, d3, d4}), 15);
    check("reset_done", int'(frame_done), 0);
    check("reset_state", int'(dbg_state), 0);

    repeat (6) @(negedge Clk);
    check_cars("idle");

    // first frame, cycle by cycle
    frame_clk = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge Clk);
      case (i)
        3: begin
          check("t3_state", int'(dbg_state), 1);
          check("t3_x1", x1, 144);
        end
        4: begin
          m_x[0] = model_move(m_x[0]);
          check("t4_x1", x1, m_x[0]);
          check("t4_x2", x2, 0);
        end
        5: begin
          m_x[1] = model_move(m_x[1]);
          check("t5_x2", x2, m_x[1]);
        end
        6: begin
          m_x[2] = model_move(m_x[2]);
          check("t6_x3", x3, m_x[2]);
          check("t6_done", int'(frame_done), 0);
        end
        7: begin
          m_x[3] = model_move(m_x[3]);
          check_cars("t7");
          check("t7_done", int'(frame_done), 1);
          check("t7_state", int'(dbg_state), 0);
        end
        8: check("t8_done", int'(frame_done), 0);
        default: ;
      endcase
    end
    frame_clk = 1'b0;
`ifdef OTHERCARLEFT_SPEEDUP_EN
    check("f1_hand_x1", x1, 139);
`else
    check("f1_hand_x1", x1, 142);
    check("f1_hand_x2", x2, -2);
    check("f1_hand_x3", x3, 430);
    check("f1_hand_x4", x4, 286);
`endif
    pulses = 0;
    repeat (10) begin
      @(negedge Clk);
      if (frame_done) pulses++;
    end
    check("held_level_extra_done", pulses, 0);

    // walk car 2 down to the wrap line
    guard = 0;
    while (m_x[1] > -32 && guard < 60) begin
      run_frame(pulses);
      for (int k = 0; k < 4; k++) m_x[k] = model_move(m_x[k]);
      guard++;
    end
    check_cars("prewrap");
    check("prewrap_done", pulses, 1);
`ifndef OTHERCARLEFT_SPEEDUP_EN
    check("wrap_at_lo", x2, -32);
    run_frame(pulses);
    check("wrap_past_lo", x2, -34);
    run_frame(pulses);
    check("wrap_reenter", x2, 672);
    run_frame(pulses);
    check("wrap_after", x2, 670);
    for (int k = 0; k < 4; k++)
      for (int f = 0; f < 3; f++) m_x[k] = model_move(m_x[k]);
    check_cars("wrap");
`endif

    // halt freezes traffic
    halt = 1'b1;
    guard = 0;
    for (int f = 0; f < 5; f++) begin
      run_frame(pulses);
      guard += pulses;
    end
    check("halt_no_done", guard, 0);
    check_cars("halt");
    halt = 1'b0;

    // halt raised mid-sequence lets the sequence finish
    @(negedge Clk);
    frame_clk = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge Clk);
      if (dbg_state == UPD2) found = 1'b1;
    end
    check("reach_upd2", int'(found), 1);
    halt = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge Clk);
      if (frame_done) found = 1'b1;
    end
    check("halt_mid_done", int'(found), 1);
    for (int k = 0; k < 4; k++) m_x[k] = model_move(m_x[k]);
    check_cars("halt_mid");
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    halt = 1'b0;
    repeat (4) @(negedge Clk);

    // reset during UPD3
    frame_clk = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge Clk);
      if (dbg_state == UPD3) found = 1'b1;
    end
    check("reach_upd3", int'(found), 1);
    m_x[0] = model_move(m_x[0]);
    m_x[1] = model_move(m_x[1]);
    check("upd3_x1", x1, m_x[0]);
    check("upd3_x2", x2, m_x[1]);
    Reset = 1'b1;
    frame_clk = 1'b0;
    @(negedge Clk);
    model_reset();
    check_cars("midreset");
    check("midreset_state", int'(dbg_state), 0);
    check("midreset_done", int'(frame_done), 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge Clk);
      if (frame_done) pulses++;
    end
    check("midreset_no_done", pulses, 0);
    check_cars("postreset");

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
